// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the dual-issue fetch front end.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned FETCH_BYTES     = 8;
    localparam logic [31:0] PAIR_ALIGN_MASK = ~32'h7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_ADVANCE  = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_gen
//  Brief    : Fetch PC register with hold / pair-advance / redirect select.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_e           pc_sel,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(~PAIR_ALIGN_MASK);
    localparam logic [ADDR_W-1:0] c_word_mask  = ~ADDR_W'(3);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Advancing always lands on the next pair boundary, so a mid-pair entry re-aligns.
    always_comb begin
        w_pc_next = r_pc;
        unique case (pc_sel)
            PC_ADVANCE:  w_pc_next = (r_pc & c_align_mask) + ADDR_W'(FETCH_BYTES);
            PC_REDIRECT: w_pc_next = redirect_addr & c_word_mask;
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Dual-issue fetch front end: I-cache pair requests, FIFO push,
//             redirect handling with wrong-path response discard.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop_fetch,
    input  logic              jump,
    input  logic              jump_accept,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_ready,
    input  logic              icache_rvalid,
    input  logic [63:0]       icache_rdata,
    output logic              fifo_push,
    output logic [31:0]       fifo_instr1,
    output logic [31:0]       fifo_instr2,
    output logic              fifo_valid1,
    output logic              fifo_valid2,
    output logic [ADDR_W-1:0] fifo_pc
);

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(~PAIR_ALIGN_MASK);

    state_e            r_state;
    state_e            w_next_state;
    pc_sel_e           w_pc_sel;
    logic              w_latch;
    logic              w_redirect;
    logic              w_hs;
    logic              w_req;
    logic              w_push;
    logic [63:0]       w_push_data;
    logic [63:0]       r_hold_data;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pair_pc;

    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel        (w_pc_sel),
        .redirect_addr (jump_addr),
        .pc            (w_pc)
    );

    assign w_redirect = jump & jump_accept;
    assign w_hs       = w_req & icache_ready;
    assign w_pair_pc  = w_pc & c_align_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_sel     = PC_HOLD;
        w_latch      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next_state = REQ;
                if (w_redirect) w_pc_sel = PC_REDIRECT;
            end
            REQ: begin
                if (w_redirect) begin
                    w_pc_sel = PC_REDIRECT;
                    if (w_hs) w_next_state = DROP;
                end else if (w_hs) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                // A response arriving with the redirect is simply dropped here.
                if (w_redirect) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = icache_rvalid ? REQ : DROP;
                end else if (icache_rvalid) begin
                    if (stop_fetch) begin
                        w_latch      = 1'b1;
                        w_next_state = HOLD;
                    end else begin
                        w_pc_sel     = PC_ADVANCE;
                        w_next_state = REQ;
                    end
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = REQ;
                end else if (!stop_fetch) begin
                    w_pc_sel     = PC_ADVANCE;
                    w_next_state = REQ;
                end
            end
            DROP: begin
                if (w_redirect) w_pc_sel = PC_REDIRECT;
                if (icache_rvalid) w_next_state = REQ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_req       = 1'b0;
        w_push      = 1'b0;
        w_push_data = r_hold_data;
        unique case (r_state)
            REQ:  w_req = !stop_fetch;
            WAIT: begin
                w_push      = icache_rvalid & !stop_fetch & !w_redirect;
                w_push_data = icache_rdata;
            end
            HOLD: w_push = !stop_fetch & !w_redirect;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_data <= '0;
        end else if (w_latch) begin
            r_hold_data <= icache_rdata;
        end
    end

    assign icache_req  = w_req;
    assign icache_addr = w_pair_pc;
    assign fifo_push   = w_push;
    assign fifo_instr1 = w_push ? w_push_data[31:0]  : 32'h0;
    assign fifo_instr2 = w_push ? w_push_data[63:32] : 32'h0;
    assign fifo_valid1 = w_push & ~w_pc[2];
    assign fifo_valid2 = w_push;
    assign fifo_pc     = w_push ? w_pair_pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed + random bench for fetch_unit against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stop_fetch, jump, jump_accept;
    logic [31:0] jump_addr;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready, icache_rvalid;
    logic [63:0] icache_rdata;
    logic        fifo_push;
    logic [31:0] fifo_instr1, fifo_instr2;
    logic        fifo_valid1, fifo_valid2;
    logic [31:0] fifo_pc;

    fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stop_fetch    (stop_fetch),
        .jump          (jump),
        .jump_accept   (jump_accept),
        .jump_addr     (jump_addr),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ready  (icache_ready),
        .icache_rvalid (icache_rvalid),
        .icache_rdata  (icache_rdata),
        .fifo_push     (fifo_push),
        .fifo_instr1   (fifo_instr1),
        .fifo_instr2   (fifo_instr2),
        .fifo_valid1   (fifo_valid1),
        .fifo_valid2   (fifo_valid2),
        .fifo_pc       (fifo_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one request in flight, flagged stale if overtaken by a redirect.
    logic        m_known   = 1'b0;
    logic        m_started = 1'b0;
    logic        m_outst   = 1'b0;
    logic        m_stale   = 1'b0;
    logic        m_held    = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [63:0] m_hdata   = 64'h0;

    // Observed values of the latest cycle, for scenario-specific checks.
    logic        g_req, g_push, g_v1, g_v2;
    logic [31:0] g_addr, g_pc;
    int          g_push_cnt = 0;
    logic [31:0] acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic j, input logic ja, input logic [31:0] jaddr,
                       input logic rdy, input logic rv);
        logic        redir, e_req, hs, rsp, e_push;
        logic [63:0] rd, pdata;
        logic [31:0] apc;
        stop_fetch    = s;
        jump          = j;
        jump_accept   = ja;
        jump_addr     = jaddr;
        icache_ready  = rdy;
        icache_rvalid = rv;
        rd            = {$urandom, $urandom};
        icache_rdata  = rd;
        #2;
        redir  = j & ja;
        e_req  = m_started & !m_outst & !m_held & !s;
        hs     = e_req & rdy;
        rsp    = m_outst & rv;
        e_push = !redir & ((rsp & !m_stale & !s) | (m_held & !s));
        pdata  = rsp ? rd : m_hdata;
        apc    = m_pc & 32'hFFFF_FFF8;
        g_req  = icache_req;
        g_addr = icache_addr;
        g_push = fifo_push;
        g_v1   = fifo_valid1;
        g_v2   = fifo_valid2;
        g_pc   = fifo_pc;
        if (fifo_push === 1'b1) g_push_cnt++;
        if (icache_req === 1'b1 && rdy) acc_q.push_back(icache_addr);
        if (m_known) begin
            chk("req", {31'b0, icache_req}, {31'b0, e_req});
            if (e_req) chk("addr", icache_addr, apc);
            chk("push", {31'b0, fifo_push}, {31'b0, e_push});
            if (e_push) begin
                chk("instr1", fifo_instr1, pdata[31:0]);
                chk("instr2", fifo_instr2, pdata[63:32]);
                chk("valid1", {31'b0, fifo_valid1}, {31'b0, !m_pc[2]});
                chk("valid2", {31'b0, fifo_valid2}, 32'h1);
                chk("fifo_pc", fifo_pc, apc);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1'b1; m_started = 1'b0; m_outst = 1'b0;
            m_stale = 1'b0; m_held = 1'b0; m_pc = RESET_PC;
        end else if (m_known) begin
            if (!m_started) begin
                m_started = 1'b1;
                if (redir) m_pc = jaddr & 32'hFFFF_FFFC;
            end else begin
                logic n_outst, n_stale;
                n_outst = m_outst;
                n_stale = m_stale;
                if (rsp) n_outst = 1'b0;
                if (m_outst && !rsp && redir) n_stale = 1'b1;
                if (hs) begin n_outst = 1'b1; n_stale = redir; end
                if (rsp && !m_stale && !redir && s) begin
                    m_held  = 1'b1;
                    m_hdata = rd;
                end else if (redir || e_push) begin
                    m_held = 1'b0;
                end
                if (redir)       m_pc = jaddr & 32'hFFFF_FFFC;
                else if (e_push) m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
                m_outst = n_outst;
                m_stale = n_stale;
            end
        end
        @(negedge clk);
    endtask

    // Cache that always accepts and answers one cycle after acceptance.
    task automatic auto_cyc(input logic s);
        cyc(s, 1'b0, 1'b0, 32'h0, 1'b1, m_outst);
    endtask

    initial begin
        rst_n = 1'b0;
        stop_fetch = 1'b0; jump = 1'b0; jump_accept = 1'b0; jump_addr = '0;
        icache_ready = 1'b0; icache_rvalid = 1'b0; icache_rdata = '0;
        @(negedge clk);

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_req", {31'b0, icache_req}, 32'h0);
        chk("rst_addr", icache_addr, 32'h0);
        chk("rst_push", {31'b0, fifo_push}, 32'h0);
        chk("rst_instr1", fifo_instr1, 32'h0);
        chk("rst_instr2", fifo_instr2, 32'h0);
        chk("rst_fifo_pc", fifo_pc, 32'h0);
        rst_n = 1'b1;

        // Hit loop
        acc_q.delete();
        g_push_cnt = 0;
        repeat (7) auto_cyc(1'b0);
        chk("loop_addr0", acc_q[0], 32'h0);
        chk("loop_addr1", acc_q[1], 32'h8);
        chk("loop_addr2", acc_q[2], 32'h10);
        chk("loop_pushes", g_push_cnt, 32'd3);

        // Stall with response arriving: hold then release
        auto_cyc(1'b0);
        auto_cyc(1'b1);
        chk("hold_nopush", {31'b0, g_push}, 32'h0);
        auto_cyc(1'b1);
        auto_cyc(1'b0);
        chk("hold_push", {31'b0, g_push}, 32'h1);
        chk("hold_pc", g_pc, 32'h18);
        auto_cyc(1'b0);
        chk("hold_next", g_addr, 32'h20);

        // Redirect in WAIT before the response
        cyc(1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0);
        auto_cyc(1'b0);
        chk("drop_nopush", {31'b0, g_push}, 32'h0);
        auto_cyc(1'b0);
        chk("redir_req", {31'b0, g_req}, 32'h1);
        chk("redir_addr", g_addr, 32'h100);
        auto_cyc(1'b0);
        chk("redir_v1", {31'b0, g_v1}, 32'h0);
        chk("redir_v2", {31'b0, g_v2}, 32'h1);
        chk("redir_pc", g_pc, 32'h100);

        // Jump without accept is ignored
        cyc(1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0);
        chk("noacc_addr", g_addr, 32'h108);
        cyc(1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 1'b1);
        chk("noacc_pc", g_pc, 32'h108);
        auto_cyc(1'b0);
        chk("noacc_next", g_addr, 32'h110);

        // Redirect during HOLD with stop asserted
        auto_cyc(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        chk("hredir_nopush", {31'b0, g_push}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("hredir_stop", {31'b0, g_req}, 32'h0);
        auto_cyc(1'b0);
        chk("hredir_addr", g_addr, 32'h40);

        // Reset mid-WAIT, stale response afterwards
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("stale_push0", {31'b0, g_push}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("stale_push1", {31'b0, g_push}, 32'h0);
        chk("stale_req", {31'b0, g_req}, 32'h1);
        chk("stale_addr", g_addr, RESET_PC);

        // Address wrap at the top of memory
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        auto_cyc(1'b0);
        chk("wrap_req", g_addr, 32'hFFFF_FFF8);
        auto_cyc(1'b0);
        chk("wrap_v1", {31'b0, g_v1}, 32'h0);
        auto_cyc(1'b0);
        chk("wrap_next", g_addr, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, j, ja, rdy, rv;
            s   = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 9) == 0);
            ja  = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = m_outst & ($urandom_range(0, 9) < 6);
            cyc(s, j, ja, $urandom, rdy, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
